// File: rtl/memory_access_stage.sv
// ============================================================================
// memory_access_stage
//
// Purpose:
//   MEM stage of a RISC-V style pipeline. It turns an EX/MEM load or store
//   request into a single data-bus transaction. It formats load data back to
//   32 bits for MEM/WB. It stalls the upstream pipeline while the bus is busy.
//   Accesses that are misaligned or have an undefined size are rejected
//   without touching the bus.
//
//   FSM: IDLE -> ACCESS -> DONE -> IDLE
//     IDLE   : waits for a request. Legal requests are latched and raise
//              stall combinationally in the same cycle. Illegal requests
//              pulse misalignedFault.
//     ACCESS : drives a stable bus request until busReady is seen.
//     DONE   : releases stall and pulses loadValid for loads. The held
//              upstream op is not re-issued.
//
// Parameters:
//   TIMEOUT_CYCLES - bus wait limit in cycles (1..255). Used only when
//                    MEM_TIMEOUT_EN is defined.
//
// Configuration macro:
//   MEM_TIMEOUT_EN - when defined, an ACCESS that sees no busReady for
//                    TIMEOUT_CYCLES cycles is aborted and busFault pulses.
//                    When undefined, ACCESS waits indefinitely and busFault
//                    is tied low.
//
// Ports:
//   clock              in   rising-edge clock
//   reset              in   synchronous, active-high reset
//   address[31:0]      in   effective address (EX/MEM ALU result)
//   storeData[31:0]    in   rs2 value for stores
//   func3[2:0]         in   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   memoryReadEnable   in   load request
//   memoryWriteEnable  in   store request (wins when both are set)
//   busRequest         out  bus transaction valid
//   busWrite           out  1 = store, 0 = load
//   busAddress[31:0]   out  word-aligned address
//   busWriteData[31:0] out  store data replicated into byte lanes
//   busByteEnable[3:0] out  byte lane strobes
//   busReady           in   bus completion acknowledge
//   busReadData[31:0]  in   bus read word
//   loadData[31:0]     out  formatted load result (holds between loads)
//   loadValid          out  one-cycle pulse, loadData valid
//   stall              out  hold upstream pipeline registers
//   misalignedFault    out  one-cycle pulse, access rejected
//   busFault           out  one-cycle pulse, bus timeout
// ============================================================================
module memory_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] storeData,
    input  logic [2:0]  func3,
    input  logic        memoryReadEnable,
    input  logic        memoryWriteEnable,
    output logic        busRequest,
    output logic        busWrite,
    output logic [31:0] busAddress,
    output logic [31:0] busWriteData,
    output logic [3:0]  busByteEnable,
    input  logic        busReady,
    input  logic [31:0] busReadData,
    output logic [31:0] loadData,
    output logic        loadValid,
    output logic        stall,
    output logic        misalignedFault,
    output logic        busFault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Reject an out-of-range wait limit when the design is elaborated.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
        $error("memory_access_stage: TIMEOUT_CYCLES must be within 1..255");
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_bus_request;
    logic        r_bus_write;
    logic [31:0] r_bus_address;
    logic [31:0] r_bus_write_data;
    logic [3:0]  r_bus_byte_enable;
    logic [31:0] r_load_data;
    logic        r_load_valid;
    logic        r_misaligned_fault;

    // The load formatter needs the size/sign and the byte offset after the
    // upstream op is released, so they are kept alongside the bus fields.
    logic [2:0]  r_func3;
    logic [1:0]  r_byte_offset;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        w_enable;
    logic        w_is_store;
    logic        w_legal;
    logic        w_start;
    logic [3:0]  w_byte_enable;
    logic [31:0] w_write_data;
    logic        w_timeout;

    assign w_enable   = memoryReadEnable | memoryWriteEnable;
    assign w_is_store = memoryWriteEnable;   // both enables set -> store
    assign w_start    = w_enable & w_legal;

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_legal       = 1'b0;
        w_byte_enable = 4'b0000;
        w_write_data  = storeData;
        case (func3)
            F3_B, F3_BU: begin
                w_legal       = 1'b1;
                w_byte_enable = 4'b0001 << address[1:0];
                w_write_data  = {4{storeData[7:0]}};
            end
            F3_H, F3_HU: begin
                w_legal       = ~address[0];
                w_byte_enable = address[1] ? 4'b1100 : 4'b0011;
                w_write_data  = {2{storeData[15:0]}};
            end
            F3_W: begin
                w_legal       = (address[1:0] == 2'b00);
                w_byte_enable = 4'b1111;
                w_write_data  = storeData;
            end
            default: begin
                // 011, 110, 111 are undefined sizes and are rejected.
                w_legal = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load formatting from the latched size/offset
    // ------------------------------------------------------------------
    logic [7:0]  w_sel_byte;
    logic [15:0] w_sel_half;
    logic [31:0] w_load_formatted;

    always_comb begin
        case (r_byte_offset)
            2'd1:    w_sel_byte = busReadData[15:8];
            2'd2:    w_sel_byte = busReadData[23:16];
            2'd3:    w_sel_byte = busReadData[31:24];
            default: w_sel_byte = busReadData[7:0];
        endcase
        w_sel_half = r_byte_offset[1] ? busReadData[31:16] : busReadData[15:0];

        case (r_func3)
            F3_B:    w_load_formatted = {{24{w_sel_byte[7]}}, w_sel_byte};
            F3_BU:   w_load_formatted = {24'h000000, w_sel_byte};
            F3_H:    w_load_formatted = {{16{w_sel_half[15]}}, w_sel_half};
            F3_HU:   w_load_formatted = {16'h0000, w_sel_half};
            default: w_load_formatted = busReadData;
        endcase
    end

    // ------------------------------------------------------------------
    // Optional bus timeout
    // ------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait_count;
    logic       r_bus_fault;

    // The limit is reached in the ACCESS cycle that would make the count
    // equal TIMEOUT_CYCLES. busReady in that same cycle still wins.
    assign w_timeout = (r_wait_count == TIMEOUT_LAST);
    assign busFault  = r_bus_fault;
`else
    assign w_timeout = 1'b0;
    assign busFault  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: all state here is updated with non-blocking assignments. Every
    // register then samples the pre-edge values of the others, which
    // avoids ordering races between always blocks.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state            <= IDLE;
            r_bus_request      <= 1'b0;
            r_bus_write        <= 1'b0;
            r_bus_address      <= 32'h0;
            r_bus_write_data   <= 32'h0;
            r_bus_byte_enable  <= 4'b0000;
            r_load_data        <= 32'h0;
            r_load_valid       <= 1'b0;
            r_misaligned_fault <= 1'b0;
            r_func3            <= 3'b000;
            r_byte_offset      <= 2'b00;
`ifdef MEM_TIMEOUT_EN
            r_wait_count       <= 8'h00;
            r_bus_fault        <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; the cases below raise them for one cycle.
            r_load_valid       <= 1'b0;
            r_misaligned_fault <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_bus_fault        <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_enable) begin
                        if (w_legal) begin
                            r_state           <= ACCESS;
                            r_bus_request     <= 1'b1;
                            r_bus_write       <= w_is_store;
                            r_bus_address     <= {address[31:2], 2'b00};
                            r_bus_write_data  <= w_is_store ? w_write_data : 32'h0;
                            r_bus_byte_enable <= w_byte_enable;
                            r_func3           <= func3;
                            r_byte_offset     <= address[1:0];
`ifdef MEM_TIMEOUT_EN
                            r_wait_count      <= 8'h00;
`endif
                        end else begin
                            r_misaligned_fault <= 1'b1;
                        end
                    end
                end

                ACCESS: begin
                    if (busReady) begin
                        if (!r_bus_write) begin
                            r_load_data  <= w_load_formatted;
                            r_load_valid <= 1'b1;
                        end
                        r_state           <= DONE;
                        r_bus_request     <= 1'b0;
                        r_bus_write       <= 1'b0;
                        r_bus_address     <= 32'h0;
                        r_bus_write_data  <= 32'h0;
                        r_bus_byte_enable <= 4'b0000;
                    end else if (w_timeout) begin
                        r_state           <= IDLE;
                        r_bus_request     <= 1'b0;
                        r_bus_write       <= 1'b0;
                        r_bus_address     <= 32'h0;
                        r_bus_write_data  <= 32'h0;
                        r_bus_byte_enable <= 4'b0000;
`ifdef MEM_TIMEOUT_EN
                        r_bus_fault       <= 1'b1;
`endif
                    end else begin
`ifdef MEM_TIMEOUT_EN
                        r_wait_count <= r_wait_count + 8'h01;
`endif
                    end
                end

                DONE: begin
                    // The upstream op still on the inputs is the one just
                    // completed, so it is ignored here.
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // stall rises in the request cycle itself, so upstream holds the op
    // while it is still being latched.
    assign stall = (r_state == ACCESS) || ((r_state == IDLE) && w_start);

    assign busRequest      = r_bus_request;
    assign busWrite        = r_bus_write;
    assign busAddress      = r_bus_address;
    assign busWriteData    = r_bus_write_data;
    assign busByteEnable   = r_bus_byte_enable;
    assign loadData        = r_load_data;
    assign loadValid       = r_load_valid;
    assign misalignedFault = r_misaligned_fault;

endmodule

// File: tb/tb_memory_access_stage.sv
// ============================================================================
// tb_memory_access_stage
//
// Directed bench for memory_access_stage. The stimulus tasks drive one
// request at a time. At the same time they work out, from the access rules
// (size, alignment, lanes, extension), what every output must read in each
// cycle. A single negedge compare process checks the DUT against those
// expectations. A few hand-computed literals pin the model's arithmetic.
// ============================================================================
module tb_memory_access_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] storeData;
    logic [2:0]  func3;
    logic        memoryReadEnable;
    logic        memoryWriteEnable;
    logic        busRequest;
    logic        busWrite;
    logic [31:0] busAddress;
    logic [31:0] busWriteData;
    logic [3:0]  busByteEnable;
    logic        busReady;
    logic [31:0] busReadData;
    logic [31:0] loadData;
    logic        loadValid;
    logic        stall;
    logic        misalignedFault;
    logic        busFault;

    always #5 clock = ~clock;

    memory_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .address           (address),
        .storeData         (storeData),
        .func3             (func3),
        .memoryReadEnable  (memoryReadEnable),
        .memoryWriteEnable (memoryWriteEnable),
        .busRequest        (busRequest),
        .busWrite          (busWrite),
        .busAddress        (busAddress),
        .busWriteData      (busWriteData),
        .busByteEnable     (busByteEnable),
        .busReady          (busReady),
        .busReadData       (busReadData),
        .loadData          (loadData),
        .loadValid         (loadValid),
        .stall             (stall),
        .misalignedFault   (misalignedFault),
        .busFault          (busFault)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    // ------------------------------------------------------------------
    // Access-rule model (plain arithmetic on sizes and offsets)
    // ------------------------------------------------------------------
    function automatic int m_size(input logic [2:0] f);
        if (f[1:0] == 2'd0) return 1;
        if (f[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input logic [2:0] f, input logic [31:0] a);
        if (f == 3'b011 || f == 3'b110 || f == 3'b111) return 1'b0;
        return (a % m_size(f)) == 0;
    endfunction

    function automatic logic [3:0] m_lanes(input logic [2:0] f, input logic [31:0] a);
        int n = m_size(f);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
        int n = m_size(f);
        if (n == 1) return d[7:0] * 32'h0101_0101;
        if (n == 2) return d[15:0] * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_format(input logic [2:0] f, input logic [31:0] a, input logic [31:0] word);
        int n = m_size(f);
        logic [31:0] mask;
        logic [31:0] v;
        if (n == 4) return word;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = (word >> (8 * (a % 4))) & mask;
        if (f[2] == 1'b0 && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle expectations
    // ------------------------------------------------------------------
    bit          cmp_en = 1'b0;
    bit          exp_bus_request, exp_bus_write, exp_stall;
    bit          exp_load_valid, exp_mis_fault, exp_bus_fault;
    bit          exp_bus_care, exp_wdata_care;
    logic [31:0] exp_bus_address, exp_wdata, exp_load_data;
    logic [3:0]  exp_be;
    logic [31:0] m_load_data = 32'h0;

    // Observations for the literal checks
    int          stall_cycles, lv_count, mis_count, req_count, bf_count;
    logic [3:0]  seen_be;
    logic [31:0] seen_wdata;
    logic        seen_write;

    task automatic clear_obs();
        stall_cycles = 0; lv_count = 0; mis_count = 0; req_count = 0; bf_count = 0;
        seen_be = 4'h0; seen_wdata = 32'h0; seen_write = 1'b0;
    endtask

    task automatic set_idle_exp();
        exp_bus_request = 1'b0; exp_bus_write = 1'b0; exp_stall = 1'b0;
        exp_load_valid  = 1'b0; exp_mis_fault = 1'b0; exp_bus_fault = 1'b0;
        exp_bus_address = 32'h0; exp_wdata = 32'h0; exp_be = 4'h0;
        exp_bus_care    = 1'b1; exp_wdata_care = 1'b1;
        exp_load_data   = m_load_data;
    endtask

    task automatic set_access_exp(input bit wr, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        set_idle_exp();
        exp_bus_request = 1'b1;
        exp_stall       = 1'b1;
        exp_bus_write   = wr;
        exp_bus_address = a - (a % 4);
        exp_be          = m_lanes(f, a);
        exp_wdata       = m_wdata(f, d);
        exp_wdata_care  = wr;
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            check("stall", stall, exp_stall);
            check("busRequest", busRequest, exp_bus_request);
            check("loadValid", loadValid, exp_load_valid);
            check("loadData", loadData, exp_load_data);
            check("misalignedFault", misalignedFault, exp_mis_fault);
            check("busFault", busFault, exp_bus_fault);
            if (exp_bus_care) begin
                check("busWrite", busWrite, exp_bus_write);
                check("busAddress", busAddress, exp_bus_address);
                check("busByteEnable", busByteEnable, exp_be);
            end
            if (exp_bus_care && exp_wdata_care)
                check("busWriteData", busWriteData, exp_wdata);
            if (stall) stall_cycles++;
            if (loadValid) lv_count++;
            if (misalignedFault) mis_count++;
            if (busFault) bf_count++;
            if (busRequest) begin
                req_count++;
                seen_be    = busByteEnable;
                seen_wdata = busWriteData;
                seen_write = busWrite;
            end
        end
    end

    // ------------------------------------------------------------------
    // One complete request. ready_at = ACCESS cycle (1-based) with busReady.
    // ready_outside drives busReady high while not in ACCESS.
    // ------------------------------------------------------------------
    task automatic do_op(input bit rd, input bit wr, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rdata, input int ready_at,
                         input bit ready_outside);
        bit legal = m_legal(f, a);
        @(posedge clock); #1;
        memoryReadEnable = rd; memoryWriteEnable = wr;
        func3 = f; address = a; storeData = d; busReadData = rdata;
        busReady = ready_outside;
        set_idle_exp();
        exp_stall = legal;
        if (!legal) begin
            @(posedge clock); #1;
            memoryReadEnable = 1'b0; memoryWriteEnable = 1'b0; busReady = 1'b0;
            set_idle_exp();
            exp_mis_fault = 1'b1;
            @(posedge clock); #1;
            set_idle_exp();
            return;
        end
        for (int k = 1; k <= ready_at; k++) begin
            @(posedge clock); #1;
            busReady = (k == ready_at);
            set_access_exp(wr, f, a, d);
        end
        // DONE: upstream still shows the held op; it must not start again.
        @(posedge clock); #1;
        busReady = ready_outside;
        set_idle_exp();
        exp_bus_care = 1'b0;
        if (!wr) begin
            m_load_data    = m_format(f, a, rdata);
            exp_load_valid = 1'b1;
        end
        exp_load_data = m_load_data;
        @(posedge clock); #1;
        memoryReadEnable = 1'b0; memoryWriteEnable = 1'b0; busReady = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        reset = 1'b1;
        address = 32'h0; storeData = 32'h0; func3 = 3'b000;
        memoryReadEnable = 1'b0; memoryWriteEnable = 1'b0;
        busReady = 1'b0; busReadData = 32'h0;
        clear_obs();
        set_idle_exp();

        // Reset state
        @(posedge clock); #1;
        cmp_en = 1'b1;
        @(posedge clock); #1;
        check("reset_loadData", loadData, 32'h0);
        reset = 1'b0;

        // LB at 0x103, ready in the 3rd ACCESS cycle
        clear_obs();
        do_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_FFFF, 3, 0);
        check("lb_loadData_lit", loadData, 32'hFFFF_FF80);
        check("lb_be_lit", seen_be, 4'b1000);
        check("lb_stall_cycles", stall_cycles, 4);
        check("lb_loadValid_pulses", lv_count, 1);

        // SH at 0x202, ready in the 1st ACCESS cycle, ready also outside ACCESS
        clear_obs();
        do_op(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 1, 1);
        check("sh_be_lit", seen_be, 4'b1100);
        check("sh_wdata_lit", seen_wdata, 32'hABCD_ABCD);
        check("sh_write_lit", seen_write, 1'b1);
        check("sh_no_loadValid", lv_count, 0);

        // LW at 0x105 is misaligned
        clear_obs();
        do_op(1, 0, 3'b010, 32'h105, 32'h0, 32'h0, 1, 0);
        check("lw_mis_pulses", mis_count, 1);
        check("lw_mis_no_request", req_count, 0);
        check("lw_mis_no_stall", stall_cycles, 0);

        // LHU at 0x102 takes the upper half, zero-extended
        do_op(1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_5A5A, 2, 0);
        check("lhu_loadData_lit", loadData, 32'h0000_8001);

        // Further size/offset/sign patterns
        do_op(1, 0, 3'b001, 32'h002, 32'h0, 32'h8000_7FFF, 1, 1);   // LH upper, negative
        do_op(1, 0, 3'b001, 32'h000, 32'h0, 32'h8000_7FFF, 2, 0);   // LH lower, positive
        do_op(1, 0, 3'b100, 32'h001, 32'h0, 32'h0000_F000, 1, 0);   // LBU byte 1
        do_op(1, 0, 3'b000, 32'h000, 32'h0, 32'h1234_567F, 1, 0);   // LB byte 0, positive
        do_op(1, 0, 3'b000, 32'h002, 32'h0, 32'h00C3_0000, 2, 0);   // LB byte 2, negative
        check("lb2_loadData_lit", loadData, 32'hFFFF_FFC3);
        do_op(0, 1, 3'b000, 32'h003, 32'h0000_00AB, 32'h0, 1, 0);  // SB lane 3
        do_op(0, 1, 3'b010, 32'h010, 32'hCAFE_F00D, 32'h0, 2, 1);  // SW
        clear_obs();
        do_op(1, 1, 3'b010, 32'h020, 32'h5555_AAAA, 32'h1111_1111, 1, 0); // both -> store
        check("both_is_store", seen_write, 1'b1);
        check("both_no_loadValid", lv_count, 0);

        // Illegal encodings and misaligned halfwords
        clear_obs();
        do_op(1, 0, 3'b011, 32'h000, 32'h0, 32'h0, 1, 0);
        do_op(0, 1, 3'b110, 32'h004, 32'h0, 32'h0, 1, 0);
        do_op(1, 0, 3'b111, 32'h008, 32'h0, 32'h0, 1, 0);
        do_op(1, 0, 3'b001, 32'h001, 32'h0, 32'h0, 1, 0);
        do_op(0, 1, 3'b001, 32'h003, 32'h0, 32'h0, 1, 0);
        do_op(1, 0, 3'b101, 32'h00B, 32'h0, 32'h0, 1, 0);
        check("illegal_mis_pulses", mis_count, 6);
        check("illegal_no_request", req_count, 0);

        // Reset on the 2nd ACCESS cycle of a load, then a normal LW at 0x0
        clear_obs();
        @(posedge clock); #1;
        memoryReadEnable = 1'b1; func3 = 3'b100; address = 32'h011; busReadData = 32'hFFFF_FFFF;
        set_idle_exp(); exp_stall = 1'b1;
        @(posedge clock); #1;
        set_access_exp(0, 3'b100, 32'h011, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        set_access_exp(0, 3'b100, 32'h011, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0; memoryReadEnable = 1'b0;
        m_load_data = 32'h0;
        set_idle_exp();
        @(posedge clock); #1;
        set_idle_exp();
        check("rst_no_loadValid", lv_count, 0);
        do_op(1, 0, 3'b010, 32'h000, 32'h0, 32'hDEAD_BEEF, 1, 0);
        check("rst_lw_loadData_lit", loadData, 32'hDEAD_BEEF);
        check("rst_lw_loadValid", lv_count, 1);

        // Bus never answers
        clear_obs();
        @(posedge clock); #1;
        memoryReadEnable = 1'b1; func3 = 3'b010; address = 32'h040; busReady = 1'b0;
        set_idle_exp(); exp_stall = 1'b1;
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock); #1;
            set_access_exp(0, 3'b010, 32'h040, 32'h0);
        end
        @(posedge clock); #1;
        memoryReadEnable = 1'b0;
        set_idle_exp(); exp_bus_fault = 1'b1;
        @(posedge clock); #1;
        set_idle_exp();
        @(posedge clock); #1;
        check("timeout_busFault_pulses", bf_count, 1);
        check("timeout_no_loadValid", lv_count, 0);
`else
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock); #1;
            if (k == 20) reset = 1'b1;
            set_access_exp(0, 3'b010, 32'h040, 32'h0);
        end
        @(posedge clock); #1;
        reset = 1'b0; memoryReadEnable = 1'b0;
        m_load_data = 32'h0;
        set_idle_exp();
        @(posedge clock); #1;
        check("wait_stall_cycles", stall_cycles, 21);
        check("wait_no_busFault", bf_count, 0);
`endif

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
